// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: address/strobe sequencer for an in-place radix-2 DIT FFT
module fft_stage_sequencer #(
    parameter int N     = 16,
    parameter int LOG2N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [LOG2N-1:0] stage,
    output logic             busy,
    output logic             done
);
    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    typedef enum logic [2:0] {IDLE, RUN, GAP, FLUSH, DONE} state_t;
    state_t           state_q;
    logic [LOG2N-1:0] s_q;
    logic [KW-1:0]    k_q;
    logic             wr_en_q;
    logic [LOG2N-1:0] wr_addr_a_q;
    logic [LOG2N-1:0] wr_addr_b_q;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] addr_a;
    logic [KW-1:0]    tw_full;
    // butterfly addressing: insert a zero bit at position s into k; twiddle scales pos to the N-point ROM
    always_comb begin
        span    = LOG2N'(1) << s_q;
        pos     = LOG2N'(k_q) & (span - 1'b1);
        addr_a  = ((LOG2N'(k_q) >> s_q) << (s_q + 1'b1)) | pos;
        tw_full = KW'(pos << (S_LAST - s_q));
    end
    assign rd_en     = state_q == RUN;
    assign rd_addr_a = rd_en ? addr_a : '0;
    assign rd_addr_b = rd_en ? addr_a + span : '0;
    assign tw_addr   = rd_en ? tw_full : '0;
    assign stage     = rd_en ? s_q : '0;
    assign busy      = state_q inside {RUN, GAP, FLUSH};
    assign done      = state_q == DONE;
    assign wr_en     = wr_en_q;
    assign wr_addr_a = wr_addr_a_q;
    assign wr_addr_b = wr_addr_b_q;
    // stage/butterfly counters, control FSM, and one-cycle write-back delay matching the RAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            k_q         <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
        end else begin
            wr_en_q     <= rd_en;
            wr_addr_a_q <= rd_addr_a;
            wr_addr_b_q <= rd_addr_b;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= RUN;
                    s_q     <= '0;
                    k_q     <= '0;
                end
                RUN: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == K_LAST) state_q <= (s_q == S_LAST) ? FLUSH : GAP;
                end
                GAP: begin
                    s_q     <= s_q + 1'b1;
                    k_q     <= '0;
                    state_q <= RUN;
                end
                FLUSH:   state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed and random checks of the sequencer against a cycle-offset schedule model
module tb_fft_stage_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rd16, wr16, busy16, done16;
    logic [3:0] ra16, rb16, wa16, wb16, st16;
    logic [2:0] tw16;
    logic       rd8, wr8, busy8, done8;
    logic [2:0] ra8, rb8, wa8, wb8, st8;
    logic [1:0] tw8;
    int total = 0;
    int bad = 0;
    int cycle = 0;
    int t16 = -1;
    int t8 = -1;
    int m16 [4];
    int m8 [3];

    always #5 clk = ~clk;

    fft_stage_sequencer #(.N(16), .LOG2N(4)) u16 (
        .clk(clk), .rst(rst), .start(start),
        .rd_en(rd16), .rd_addr_a(ra16), .rd_addr_b(rb16), .tw_addr(tw16),
        .wr_en(wr16), .wr_addr_a(wa16), .wr_addr_b(wb16),
        .stage(st16), .busy(busy16), .done(done16)
    );

    fft_stage_sequencer #(.N(8), .LOG2N(3)) u8 (
        .clk(clk), .rst(rst), .start(start),
        .rd_en(rd8), .rd_addr_a(ra8), .rd_addr_b(rb8), .tw_addr(tw8),
        .wr_en(wr8), .wr_addr_a(wa8), .wr_addr_b(wb8),
        .stage(st8), .busy(busy8), .done(done8)
    );

    // t = cycles since the start was accepted (1 = first read cycle); -1 = idle
    function automatic int s_of(int n, int t);
        return (t - 1) / (n / 2 + 1);
    endfunction

    function automatic int k_of(int n, int t);
        return (t - 1) % (n / 2 + 1);
    endfunction

    function automatic bit rd_of(int n, int lg, int t);
        if (t < 1) return 1'b0;
        return s_of(n, t) < lg && k_of(n, t) < n / 2;
    endfunction

    function automatic int a_of(int n, int t);
        int sp, k;
        sp = 2 ** s_of(n, t);
        k = k_of(n, t);
        return (k / sp) * 2 * sp + k % sp;
    endfunction

    function automatic int nxt(int n, int lg, int t, bit st, bit r);
        int d;
        d = lg * (n / 2 + 1) + 1;
        if (r) return -1;
        if (t < 0) return st ? 1 : -1;
        if (t == d) return -1;
        return t + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cycle, obs, exp);
        end
    endtask

    task automatic chk_dut(input string nm, input int n, input int lg, input int t,
                           input logic [31:0] rd, ra, rb, tw, st, wr, wa, wb, bz, dn);
        int d, sp;
        bit r, rp;
        d = lg * (n / 2 + 1) + 1;
        r = rd_of(n, lg, t);
        rp = rd_of(n, lg, t - 1);
        sp = r ? 2 ** s_of(n, t) : 1;
        chk({nm, ".rd_en"}, rd, r);
        chk({nm, ".rd_addr_a"}, ra, r ? a_of(n, t) : 0);
        chk({nm, ".rd_addr_b"}, rb, r ? a_of(n, t) + sp : 0);
        chk({nm, ".tw_addr"}, tw, r ? (k_of(n, t) % sp) * (n / 2 / sp) : 0);
        chk({nm, ".stage"}, st, r ? s_of(n, t) : 0);
        chk({nm, ".wr_en"}, wr, rp);
        chk({nm, ".wr_addr_a"}, wa, rp ? a_of(n, t - 1) : 0);
        chk({nm, ".wr_addr_b"}, wb, rp ? a_of(n, t - 1) + 2 ** s_of(n, t - 1) : 0);
        chk({nm, ".busy"}, bz, t >= 1 && t < d);
        chk({nm, ".done"}, dn, t == d);
    endtask

    task automatic cyc(input logic st, input logic r);
        start = st;
        rst = r;
        @(posedge clk);
        t16 = nxt(16, 4, t16, st, r);
        t8 = nxt(8, 3, t8, st, r);
        cycle++;
        @(negedge clk);
        chk_dut("n16", 16, 4, t16, rd16, ra16, rb16, tw16, st16, wr16, wa16, wb16, busy16, done16);
        chk_dut("n8", 8, 3, t8, rd8, ra8, rb8, tw8, st8, wr8, wa8, wb8, busy8, done8);
        if (wr16 && rd_of(16, 4, t16 - 1)) m16[s_of(16, t16 - 1)] |= (1 << wa16) | (1 << wb16);
        if (wr8 && rd_of(8, 3, t8 - 1)) m8[s_of(8, t8 - 1)] |= (1 << wa8) | (1 << wb8);
    endtask

    initial begin
        cyc(0, 1);
        cyc(0, 1);
        chk("reset.busy", busy16, 0);
        chk("reset.rd_en", rd16, 0);
        cyc(0, 0);
        // single run on both sizes with the spot addresses
        foreach (m16[i]) m16[i] = 0;
        foreach (m8[i]) m8[i] = 0;
        cycle = 0;
        cyc(1, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0);
            if (cycle == 4) begin
                chk("s0k3.a", ra16, 6);
                chk("s0k3.b", rb16, 7);
                chk("s0k3.tw", tw16, 0);
            end
            if (cycle == 8) begin
                chk("n8.s1k2.a", ra8, 4);
                chk("n8.s1k2.b", rb8, 6);
                chk("n8.s1k2.tw", tw8, 0);
            end
            if (cycle == 14) begin
                chk("n8.s2k3.a", ra8, 3);
                chk("n8.s2k3.b", rb8, 7);
                chk("n8.s2k3.tw", tw8, 3);
            end
            if (cycle == 16) chk("n8.done16", done8, 1);
            if (cycle == 24) begin
                chk("s2k5.a", ra16, 9);
                chk("s2k5.b", rb16, 13);
                chk("s2k5.tw", tw16, 2);
            end
            if (cycle == 35) begin
                chk("s3k7.a", ra16, 7);
                chk("s3k7.b", rb16, 15);
                chk("s3k7.tw", tw16, 7);
            end
            if (cycle == 36) chk("done.not36", done16, 0);
            if (cycle == 37) chk("done37", done16, 1);
        end
        foreach (m16[i]) chk("n16.stage_cover", m16[i], 32'hffff);
        foreach (m8[i]) chk("n8.stage_cover", m8[i], 32'hff);
        // start held high: one run per idle visit, restart two cycles after done
        cycle = 0;
        for (int i = 0; i < 90; i++) begin
            cyc(1, 0);
            if (cycle == 38) chk("hold.idle38", busy16, 0);
            if (cycle == 39) chk("hold.rd39", rd16, 1);
        end
        for (int i = 0; i < 45; i++) cyc(0, 0);
        // reset in the middle of stage 1, then a fresh full run
        cycle = 0;
        cyc(1, 0);
        for (int i = 0; i < 11; i++) cyc(0, 0);
        cyc(0, 1);
        chk("midrst.rd_en", rd16, 0);
        chk("midrst.wr_en", wr16, 0);
        chk("midrst.busy", busy16, 0);
        chk("midrst.done", done16, 0);
        cyc(0, 0);
        cycle = 0;
        cyc(1, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0);
            if (cycle == 37) chk("rerun.done37", done16, 1);
        end
        // random start pulses and occasional resets
        for (int i = 0; i < 400; i++) cyc(($urandom % 4) == 0, ($urandom % 60) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
